// File: rtl/cpu_pkg.sv
// Shared types for the binary-to-BCD display path.
// Digit type and converter FSM state encoding.
package cpu_pkg;

  typedef logic [3:0] bcd_digit_t;

  typedef enum logic [1:0] {
    IDLE,
    SHIFT,
    DONE
  } bcd_state_t;

endpackage

// File: rtl/dd_adjust.sv
// Double-dabble nibble correction.
// Adds 3 to a BCD digit of 5 or more ahead of the shift.
module dd_adjust
  import cpu_pkg::*;
(
  input  bcd_digit_t d,
  output bcd_digit_t q
);

  always_comb begin
    q = d;
    if (d >= 4'd5)
      q = d + 4'd3;
  end

endmodule

// File: rtl/bin_to_bcd_seq.sv
// Sequential double-dabble binary-to-BCD converter.
// One shift-and-adjust step per cycle; result held between dones.
module bin_to_bcd_seq
  import cpu_pkg::*;
#(
  parameter int WIDTH  = 8,
  parameter int DIGITS = 4
) (
  input  logic                  cpu_clk,
  input  logic                  rst,
  input  logic                  start,
  input  logic [WIDTH-1:0]      bin,
  input  logic                  signed_mode,
  output logic                  busy,
  output logic                  done,
  output logic [4*DIGITS-1:0]   bcd,
  output logic                  neg,
  output logic                  overflow
);

  localparam int NW = 4 * (DIGITS + 1);
  localparam int SW = NW + 1;
  localparam int CW = $clog2(WIDTH + 1);

  bcd_state_t       state;
  bcd_state_t       state_nxt;
  logic [WIDTH-1:0] binreg;
  logic [WIDTH-1:0] mag;
  logic [SW-1:0]    scr;
  logic [NW-1:0]    scr_adj;
  logic [SW-1:0]    scr_nxt;
  logic [CW-1:0]    cnt;
  logic             neg_cap;
  logic             accept;
  logic             last;

  for (genvar g = 0; g <= DIGITS; g++) begin : g_adj
    dd_adjust u_adj (
      .d(scr[4*g +: 4]),
      .q(scr_adj[4*g +: 4])
    );
  end

  // Carry bit is sticky so a bit shifted past it still flags overflow.
  assign scr_nxt = {scr_adj[NW-1] | scr[SW-1],
                    scr_adj[NW-2:0],
                    binreg[WIDTH-1]};

  assign mag    = (signed_mode && bin[WIDTH-1]) ? -bin : bin;
  assign accept = start && (state == IDLE || state == DONE);
  assign last   = (state == SHIFT) && (cnt == CW'(1));
  assign busy   = (state == SHIFT);
  assign done   = (state == DONE);

  always_ff @(posedge cpu_clk or posedge rst) begin
    if (rst)
      state <= IDLE;
    else
      state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    unique case (state)
      IDLE:    if (start) state_nxt = SHIFT;
      SHIFT:   if (last) state_nxt = DONE;
      DONE:    state_nxt = start ? SHIFT : IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge cpu_clk or posedge rst) begin
    if (rst) begin
      binreg   <= '0;
      scr      <= '0;
      cnt      <= '0;
      neg_cap  <= 1'b0;
      bcd      <= '0;
      neg      <= 1'b0;
      overflow <= 1'b0;
    end else if (accept) begin
      binreg  <= mag;
      scr     <= '0;
      cnt     <= CW'(WIDTH);
      neg_cap <= signed_mode & bin[WIDTH-1];
    end else if (state == SHIFT) begin
      binreg <= binreg << 1;
      scr    <= scr_nxt;
      cnt    <= cnt - 1'b1;
      if (last) begin
        bcd      <= scr_nxt[4*DIGITS-1:0];
        neg      <= neg_cap;
        overflow <= |scr_nxt[SW-1:4*DIGITS];
      end
    end
  end

endmodule

// File: tb/tb_bin_to_bcd_seq.sv
// Self-checking bench for bin_to_bcd_seq.
// Covers 8-bit and 14-bit instances with tables, sequences and random values.
module tb_bin_to_bcd_seq;

  logic        cpu_clk = 1'b0;
  logic        rst = 1'b1;

  logic        start8 = 1'b0;
  logic [7:0]  bin8 = '0;
  logic        sm8 = 1'b0;
  logic        busy8, done8, neg8, ovf8;
  logic [15:0] bcd8;

  logic        start14 = 1'b0;
  logic [13:0] bin14 = '0;
  logic        sm14 = 1'b0;
  logic        busy14, done14, neg14, ovf14;
  logic [15:0] bcd14;

  int n_checks = 0;
  int n_fail = 0;

  always #5 cpu_clk = ~cpu_clk;

  bin_to_bcd_seq #(.WIDTH(8), .DIGITS(4)) u_dut8 (
    .cpu_clk(cpu_clk), .rst(rst), .start(start8), .bin(bin8),
    .signed_mode(sm8), .busy(busy8), .done(done8), .bcd(bcd8),
    .neg(neg8), .overflow(ovf8)
  );

  bin_to_bcd_seq #(.WIDTH(14), .DIGITS(4)) u_dut14 (
    .cpu_clk(cpu_clk), .rst(rst), .start(start14), .bin(bin14),
    .signed_mode(sm14), .busy(busy14), .done(done14), .bcd(bcd14),
    .neg(neg14), .overflow(ovf14)
  );

  typedef struct {
    logic [7:0]  b;
    logic        s;
    logic [15:0] e;
    logic        n;
  } vec8_t;

  typedef struct {
    logic [13:0] b;
    logic        s;
    logic [15:0] e;
    logic        n;
    logic        o;
  } vec14_t;

  task automatic chk(input string nm, input logic [31:0] act,
                     input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  // Reference: low four decimal digits of a magnitude by plain arithmetic.
  function automatic logic [15:0] to_bcd(input int unsigned m);
    logic [15:0] r;
    r = '0;
    for (int i = 0; i < 4; i++) begin
      r[4*i +: 4] = 4'(m % 10);
      m = m / 10;
    end
    return r;
  endfunction

  task automatic conv8(input logic [7:0] b, input logic s,
                       input string nm);
    int unsigned mag;
    logic [15:0] prev;
    int          lat;
    logic        hold_ok, busy_ok;
    mag = (s && b[7]) ? 256 - int'(b) : int'(b);
    prev = bcd8;
    @(negedge cpu_clk);
    start8 = 1'b1; bin8 = b; sm8 = s;
    @(posedge cpu_clk); #1;
    start8 = 1'b0; bin8 = 8'($urandom); sm8 = 1'($urandom);
    lat = 0; hold_ok = 1'b1; busy_ok = 1'b1;
    for (int c = 1; c <= 20; c++) begin
      if (done8) begin
        lat = c;
        break;
      end
      if (!busy8) busy_ok = 1'b0;
      if (bcd8 !== prev) hold_ok = 1'b0;
      @(posedge cpu_clk); #1;
    end
    chk({nm, " latency"}, lat, 9);
    chk({nm, " bcd"}, bcd8, to_bcd(mag));
    chk({nm, " neg"}, neg8, s & b[7]);
    chk({nm, " ovf"}, ovf8, mag >= 10000);
    chk({nm, " busy"}, busy_ok, 1);
    chk({nm, " hold"}, hold_ok, 1);
    @(posedge cpu_clk); #1;
    chk({nm, " pulse"}, {busy8, done8}, 2'b00);
  endtask

  task automatic conv14(input logic [13:0] b, input logic s,
                        input string nm);
    int unsigned mag;
    int          lat;
    mag = (s && b[13]) ? 16384 - int'(b) : int'(b);
    @(negedge cpu_clk);
    start14 = 1'b1; bin14 = b; sm14 = s;
    @(posedge cpu_clk); #1;
    start14 = 1'b0; bin14 = 14'($urandom);
    lat = 0;
    for (int c = 1; c <= 30; c++) begin
      if (done14) begin
        lat = c;
        break;
      end
      @(posedge cpu_clk); #1;
    end
    chk({nm, " latency"}, lat, 15);
    chk({nm, " bcd"}, bcd14, to_bcd(mag));
    chk({nm, " neg"}, neg14, s & b[13]);
    chk({nm, " ovf"}, ovf14, mag >= 10000);
    @(posedge cpu_clk); #1;
  endtask

  vec8_t  tab8[8];
  vec14_t tab14[6];

  initial begin
    int done_cyc[$];
    logic [15:0] done_val[$];
    int ndone;
    int cyc;
    logic [7:0] nxt;

    tab8[0] = '{8'd0,   1'b0, 16'h0000, 1'b0};
    tab8[1] = '{8'd255, 1'b0, 16'h0255, 1'b0};
    tab8[2] = '{8'd9,   1'b0, 16'h0009, 1'b0};
    tab8[3] = '{8'h80,  1'b1, 16'h0128, 1'b1};
    tab8[4] = '{8'hFF,  1'b1, 16'h0001, 1'b1};
    tab8[5] = '{8'h7F,  1'b1, 16'h0127, 1'b0};
    tab8[6] = '{8'h80,  1'b0, 16'h0128, 1'b0};
    tab8[7] = '{8'd100, 1'b0, 16'h0100, 1'b0};

    tab14[0] = '{14'd12345, 1'b0, 16'h2345, 1'b0, 1'b1};
    tab14[1] = '{14'd9999,  1'b0, 16'h9999, 1'b0, 1'b0};
    tab14[2] = '{14'd10000, 1'b0, 16'h0000, 1'b0, 1'b1};
    tab14[3] = '{14'd16383, 1'b0, 16'h6383, 1'b0, 1'b1};
    tab14[4] = '{14'h2000,  1'b1, 16'h8192, 1'b1, 1'b0};
    tab14[5] = '{14'd0,     1'b0, 16'h0000, 1'b0, 1'b0};

    repeat (3) @(posedge cpu_clk);
    #1;
    chk("reset outputs", {busy8, done8, bcd8, neg8, ovf8}, '0);
    chk("reset outputs 14", {busy14, done14, bcd14, neg14, ovf14}, '0);
    @(negedge cpu_clk);
    rst = 1'b0;

    for (int i = 0; i < 8; i++) begin
      conv8(tab8[i].b, tab8[i].s, $sformatf("tab8[%0d]", i));
      chk($sformatf("tab8[%0d] exp bcd", i), bcd8, tab8[i].e);
      chk($sformatf("tab8[%0d] exp neg", i), neg8, tab8[i].n);
    end

    for (int i = 0; i < 6; i++) begin
      conv14(tab14[i].b, tab14[i].s, $sformatf("tab14[%0d]", i));
      chk($sformatf("tab14[%0d] exp", i), {bcd14, neg14, ovf14},
          {tab14[i].e, tab14[i].n, tab14[i].o});
    end

    // Back-to-back: start held, next value presented at each done.
    @(negedge cpu_clk);
    start8 = 1'b1; bin8 = 8'd1; sm8 = 1'b0;
    nxt = 8'd2;
    for (int c = 1; c <= 30; c++) begin
      @(posedge cpu_clk); #1;
      if (done8) begin
        done_cyc.push_back(c);
        done_val.push_back(bcd8);
        bin8 = nxt;
        nxt = nxt + 8'd1;
      end
    end
    start8 = 1'b0;
    chk("b2b count", done_cyc.size(), 3);
    if (done_cyc.size() == 3) begin
      for (int i = 0; i < 3; i++) begin
        chk($sformatf("b2b cycle %0d", i), done_cyc[i], 9 * (i + 1));
        chk($sformatf("b2b value %0d", i), done_val[i], to_bcd(i + 1));
      end
    end
    cyc = 0;
    while ((busy8 || done8) && cyc < 20) begin
      @(posedge cpu_clk); #1;
      cyc++;
    end
    chk("b2b drain", {busy8, done8}, 2'b00);

    // Start pulses during busy must not disturb the running conversion.
    @(negedge cpu_clk);
    start8 = 1'b1; bin8 = 8'd77; sm8 = 1'b0;
    @(posedge cpu_clk); #1;
    start8 = 1'b0;
    cyc = 1;
    while (!done8 && cyc < 20) begin
      start8 = cyc[0];
      bin8 = 8'd200;
      @(posedge cpu_clk); #1;
      cyc++;
    end
    start8 = 1'b0;
    chk("busy start latency", cyc, 9);
    chk("busy start value", bcd8, 16'h0077);
    @(posedge cpu_clk); #1;

    // Reset in cycle 4 aborts immediately with no done.
    @(negedge cpu_clk);
    start8 = 1'b1; bin8 = 8'd200; sm8 = 1'b0;
    @(posedge cpu_clk); #1;
    start8 = 1'b0;
    repeat (3) @(posedge cpu_clk);
    #2;
    rst = 1'b1;
    #1;
    chk("abort outputs", {busy8, done8, bcd8, neg8, ovf8}, '0);
    @(negedge cpu_clk);
    rst = 1'b0;
    ndone = 0;
    for (int c = 0; c < 12; c++) begin
      @(posedge cpu_clk); #1;
      if (done8 || busy8) ndone++;
    end
    chk("abort no done", ndone, 0);
    conv8(8'd42, 1'b0, "after abort");
    chk("after abort exp", bcd8, 16'h0042);

    for (int i = 0; i < 30; i++)
      conv8(8'($urandom), 1'($urandom), $sformatf("rnd8[%0d]", i));
    for (int i = 0; i < 8; i++)
      conv14(14'($urandom), 1'($urandom), $sformatf("rnd14[%0d]", i));

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/bin_to_bcd_seq.md
# bin_to_bcd_seq

Sequential double-dabble converter from a binary value to packed BCD digits, clocked on cpu_clk. It sits between the output register's latched value and the seven-segment digit decoder/mux, replacing wide combinational divide/modulo logic with one shift-and-adjust iteration per cycle. The previous result holds stable on the outputs while a new conversion runs, so the display never shows intermediate digits.

## Interface
- WIDTH, 8, binary input width (≥ 2)
- DIGITS, 4, number of BCD digits presented on bcd
- cpu_clk  input  1  conversion clock, rising edge
- rst  input  1  reset rst, asynchronous, active-high; clock cpu_clk
- start  input  1  request conversion of bin; sampled only in IDLE or DONE
- bin  input  WIDTH  value to convert, captured on the accepting edge
- signed_mode  input  1  captured with bin; 1 = treat bin as two's complement
- busy  output  1  conversion in progress
- done  output  1  one-cycle pulse: bcd/neg/overflow just updated
- bcd  output  4*DIGITS  result, digit 0 (units) in bits [3:0]
- neg  output  1  result is negative (signed_mode=1 and bin MSB=1)
- overflow  output  1  magnitude ≥ 10^DIGITS; bcd holds the low DIGITS digits

## Operation
- States: IDLE, SHIFT, DONE.
- IDLE/DONE + start=1: capture magnitude into the binary shift register. The magnitude is bin, or −bin as WIDTH-bit unsigned when signed_mode & bin[WIDTH-1]; the most negative value is therefore represented exactly. Capture the neg flag, clear the BCD scratch, set iteration counter to WIDTH, go to SHIFT.
- SHIFT, each cycle: every scratch nibble ≥ 5 gets +3, then shift {scratch, binreg} left one bit; decrement counter. On the iteration where counter reaches 0, write the shifted scratch to bcd, update neg and overflow, pulse done, go to DONE.
- Scratch is DIGITS+1 nibbles wide plus one carry bit. overflow = extra nibble ≠ 0 or carry set.
- DONE: lasts one cycle. With start=1, accept as from IDLE (back-to-back); otherwise go to IDLE.
- start in SHIFT is ignored; no queueing.
- bcd, neg, overflow change only on the done edge.

## Timing
- Reset values: state IDLE, busy 0, done 0, bcd 0, neg 0, overflow 0, internal registers 0.
- start high in cycle 0 → busy high in cycles 1..WIDTH → done high and result valid in cycle WIDTH+1. Latency is WIDTH+1 cycles; default 9.
- Back-to-back: start held continuously gives one result every WIDTH+1 cycles.
- Asynchronous reset during SHIFT aborts immediately. Outputs return to reset values, and no done is emitted for the aborted conversion.
- bin and signed_mode may change freely after the accepting edge.

## Structure
- Shared package cpu_pkg holds the bcd_digit_t typedef (logic [3:0]) and the bcd_state_t enum {IDLE, SHIFT, DONE}.
- Sub-module dd_adjust: combinational, one nibble in and out, +3 when ≥ 5. Instantiate DIGITS+1 times via generate.
- Counter width is $clog2(WIDTH+1).

## Test plan
- Reset, then start with bin=0 → done in cycle 9, bcd=16'h0000, neg=0, overflow=0; busy high in cycles 1–8 only.
- bin=8'd255, signed_mode=0 → bcd=16'h0255. Then bin=8'd9 → 16'h0009, with bcd holding 0255 throughout the second conversion.
- signed_mode=1: bin=8'h80 → bcd=16'h0128, neg=1; bin=8'hFF → 16'h0001, neg=1; bin=8'h7F → 16'h0127, neg=0.
- start=1 held for 30 cycles with bin stepping 1, 2, 3 at each done → three results in cycles 9, 18, 27. start pulses during busy do not change the sequence.
- Assert rst in cycle 4 of a conversion of 200 → all outputs 0 immediately, no done pulse. A new conversion of 42 then gives 16'h0042 after 9 cycles.
- WIDTH=14, DIGITS=4: bin=12345 → bcd=16'h2345, overflow=1, done at cycle 15. bin=9999 → 16'h9999, overflow=0.
